// File: rtl/serial_subtractor.sv
// ============================================================================
// serial_subtractor : bit-serial two's-complement subtractor, y = a - b,
//                     one bit per clock, LSB first, with start/done handshake.
// Revision 1.0
// ============================================================================
`default_nettype none

module serial_subtractor #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic             borrow_out,
  output logic             overflow,
  output logic             zero
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   res_q;
  logic               br_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               a_msb_q;
  logic               b_msb_q;

  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   y_q;
  logic               borrow_q;
  logic               overflow_q;
  logic               zero_q;

  // Full-subtractor cell operating on the current LSBs of the operand registers.
  logic               ai_w;
  logic               bi_w;
  logic               diff_w;
  logic               br_d;
  logic [WIDTH-1:0]   res_d;
  logic               last_w;

  assign ai_w   = a_q[0];
  assign bi_w   = b_q[0];
  assign diff_w = ai_w ^ bi_w ^ br_q;
  assign br_d   = (~ai_w & bi_w) | (~(ai_w ^ bi_w) & br_q);
  assign res_d  = {diff_w, res_q[WIDTH-1:1]};
  assign last_w = (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      br_q       <= 1'b0;
      cnt_q      <= '0;
      a_msb_q    <= 1'b0;
      b_msb_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      y_q        <= '0;
      borrow_q   <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            a_msb_q <= a[WIDTH-1];
            b_msb_q <= b[WIDTH-1];
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          a_q   <= {1'b0, a_q[WIDTH-1:1]};
          b_q   <= {1'b0, b_q[WIDTH-1:1]};
          res_q <= res_d;
          br_q  <= br_d;
          cnt_q <= cnt_q + CNT_W'(1);
          // Final bit: publish the completed result and flags in the same edge.
          if (last_w) begin
            y_q        <= res_d;
            borrow_q   <= br_d;
            overflow_q <= (a_msb_q != b_msb_q) & (res_d[WIDTH-1] != a_msb_q);
            zero_q     <= (res_d == '0);
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= S_DONE;
          end
        end

        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign y          = y_q;
  assign borrow_out = borrow_q;
  assign overflow   = overflow_q;
  assign zero       = zero_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor against an arithmetic reference model.
`default_nettype none

module tb_serial_subtractor;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] y;
  logic         borrow_out;
  logic         overflow;
  logic         zero;

  int checks;
  int failures;

  logic [W-1:0] prev_y;
  logic         prev_b;
  logic         prev_o;
  logic         prev_z;

  serial_subtractor #(.WIDTH(W), .CNT_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .y          (y),
    .borrow_out (borrow_out),
    .overflow   (overflow),
    .zero       (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                       output logic [W-1:0] ey, output logic eb,
                       output logic eo, output logic ez);
    int sa, sb, sd;
    sa = $signed(ma);
    sb = $signed(mb);
    sd = sa - sb;
    ey = W'(int'(ma) - int'(mb));
    eb = (int'(ma) < int'(mb));
    eo = (sd > 32767) || (sd < -32768);
    ez = (ey == '0);
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input bit inject);
    logic [W-1:0] ey;
    logic eb, eo, ez;
    int k;
    bit seen;
    bit extra;
    model(ta, tb_v, ey, eb, eo, ez);
    @(negedge clk);
    start = 1'b1;
    a = ta;
    b = tb_v;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    check("busy_after_accept", 32'(busy), 32'd1);
    seen = 1'b0;
    for (k = 1; k <= W + 4; k++) begin
      if (inject && k == 5) begin
        start = 1'b1;
        a = W'($urandom);
        b = W'($urandom);
      end
      if (inject && k == 7) start = 1'b0;
      @(posedge clk); #1;
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (k == 3) begin
        check("hold_y", 32'(y), 32'(prev_y));
        check("hold_borrow", 32'(borrow_out), 32'(prev_b));
        check("hold_ovf", 32'(overflow), 32'(prev_o));
        check("hold_zero", 32'(zero), 32'(prev_z));
      end
      if (k == W - 1) check("busy_late", 32'(busy), 32'd1);
    end
    if (!seen) begin
      check("done_timeout", 32'd0, 32'd1);
    end else begin
      check("latency", 32'(k), 32'(W));
      check("busy_at_done", 32'(busy), 32'd0);
      check("y", 32'(y), 32'(ey));
      check("borrow_out", 32'(borrow_out), 32'(eb));
      check("overflow", 32'(overflow), 32'(eo));
      check("zero", 32'(zero), 32'(ez));
      @(posedge clk); #1;
      check("done_one_cycle", 32'(done), 32'd0);
      if (inject) begin
        extra = 1'b0;
        repeat (W + 2) begin
          @(posedge clk); #1;
          if (done || busy) extra = 1'b1;
        end
        check("no_second_op", 32'(extra), 32'd0);
        check("y_unchanged", 32'(y), 32'(ey));
      end
    end
    prev_y = ey;
    prev_b = eb;
    prev_o = eo;
    prev_z = ez;
  endtask

  initial begin
    int k;
    int npulse;
    int last_t;
    bit unstable;
    bit dseen;
    checks   = 0;
    failures = 0;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #3;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_y", 32'(y), 32'd0);
    check("rst_zero", 32'(zero), 32'd1);
    check("rst_borrow", 32'(borrow_out), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    prev_y = '0; prev_b = 1'b0; prev_o = 1'b0; prev_z = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_op(16'h1234, 16'h0234, 1'b0);
    run_op(16'h0000, 16'h0001, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b0);
    run_op(16'h7FFF, 16'hFFFF, 1'b0);
    run_op(16'h5555, 16'h5555, 1'b1);

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    start = 1'b1;
    a = 16'hFFFF;
    b = 16'h0001;
    @(posedge clk); #1;
    start = 1'b0;
    for (k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    check("midrst_y", 32'(y), 32'd0);
    check("midrst_zero", 32'(zero), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_borrow", 32'(borrow_out), 32'd0);
    prev_y = '0; prev_b = 1'b0; prev_o = 1'b0; prev_z = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    dseen = 1'b0;
    repeat (W + 4) begin
      @(posedge clk); #1;
      if (done || busy) dseen = 1'b1;
    end
    check("no_done_after_rst", 32'(dseen), 32'd0);
    run_op(16'h0003, 16'h0005, 1'b0);

    // Start held high: back-to-back operations every W+2 clocks.
    @(negedge clk);
    start = 1'b1;
    a = 16'h0010;
    b = 16'h0008;
    npulse   = 0;
    last_t   = 0;
    unstable = 1'b0;
    for (k = 1; k <= 3 * (W + 2) + 10; k++) begin
      @(posedge clk); #1;
      if (done) begin
        if (npulse > 0) check("cont_interval", 32'(k - last_t), 32'(W + 2));
        check("cont_y", 32'(y), 32'h0008);
        npulse++;
        last_t = k;
        if (npulse == 3) begin
          start = 1'b0;
          break;
        end
      end else if (npulse > 0 && y !== 16'h0008) begin
        unstable = 1'b1;
      end
    end
    check("cont_pulses", 32'(npulse), 32'd3);
    check("cont_y_stable", 32'(unstable), 32'd0);
    prev_y = 16'h0008; prev_b = 1'b0; prev_o = 1'b0; prev_z = 1'b0;
    repeat (3) @(posedge clk);

    repeat (30) run_op(W'($urandom), W'($urandom), 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial WIDTH-bit two's-complement subtractor, computing y = a - b. It is the subtract-direction counterpart of the combinational ripple adders.
- One full-subtractor cell plus a borrow flip-flop; it processes one bit per clock, LSB first.
- Start/done handshake. Results and flags are held stable between operations.
- Sits beside the adder datapath where area matters more than latency.

Parameters:
- WIDTH, 16, operand/result width in bits (must be >= 2).
- CNT_W, 5, bit-counter width (must satisfy 2^CNT_W > WIDTH).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a subtraction; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on the accepting edge.
- b  input  WIDTH  subtrahend; captured on the accepting edge.
- busy  output  1  high while an operation is in progress (SHIFT state).
- done  output  1  one-cycle pulse when results update.
- y  output  WIDTH  difference a - b mod 2^WIDTH.
- borrow_out  output  1  final borrow (1 when unsigned a < b).
- overflow  output  1  signed overflow.
- zero  output  1  y == 0.

Interface rule (already decided): one clock, clk; reset rst is asynchronous and active-high.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - state = IDLE; busy, done, borrow_out, overflow = 0; y = 0; zero = 1.
  - Internal shift registers, borrow FF and counter cleared.
  - An in-flight operation is discarded; no done pulse follows.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start = 1 at edge E0: latch a and b into shift registers, borrow FF = 0, count = 0, go to SHIFT.
  - start = 0: remain in IDLE.
- SHIFT (busy = 1), edges E1..E_WIDTH, one bit per edge, bit i = count:
  - d = ai ^ bi ^ br
  - br_next = (~ai & bi) | (~(ai ^ bi) & br)
  - d shifts into the MSB of the internal result register (shift right); operand registers shift right; count increments.
  - At the edge where count == WIDTH-1, go to DONE.
  - At that same edge, register the outputs:
    - y = completed result
    - borrow_out = br_next
    - overflow = (a_msb != b_msb) & (y_msb != a_msb), using the original operand MSBs (captured at E0)
    - zero = (y == 0)
    - done = 1
- DONE: done high for exactly one cycle; at the next edge done = 0 and state = IDLE.
- Latency: done is visible in the cycle after edge E_WIDTH, i.e. WIDTH clocks after the start-sampling edge. Throughput is one operation per WIDTH + 2 clocks.
- start is ignored in SHIFT and DONE. No queuing; operand changes during SHIFT have no effect.
- y, borrow_out, overflow and zero change only at completion (or reset). They keep the previous result while busy.
- busy and done are never high simultaneously.
- start held continuously high: a new operation is accepted on each return to IDLE.
- All arithmetic is mod 2^WIDTH. a == b gives y = 0, zero = 1, borrow_out = 0.

Test Plan:
- a=0x1234, b=0x0234, start one cycle -> after 16 clocks done pulses 1 cycle; y=0x1000, borrow_out=0, overflow=0, zero=0; busy high for exactly 16 cycles.
- a=0x0000, b=0x0001 -> y=0xFFFF, borrow_out=1, overflow=0, zero=0.
- a=0x8000, b=0x0001 -> y=0x7FFF, overflow=1, borrow_out=0; also a=0x7FFF, b=0xFFFF -> y=0x8000, overflow=1, borrow_out=1.
- a=0x5555, b=0x5555 -> y=0x0000, zero=1, borrow_out=0; then pulse start with new operands during SHIFT -> ignored, first result unchanged, single done pulse.
- Start a=0xFFFF, b=0x0001; assert rst at clock 7 of SHIFT -> all outputs immediately reset values (y=0, zero=1, busy=0); no done pulse; next op a=3, b=5 -> y=0xFFFE, borrow_out=1.
- start held high with a=0x0010, b=0x0008 -> done pulses every 18 clocks, y=0x0008 each time, y stable between pulses.
